redmule_core_data_demux: RTL
============================

// Module: redmule_core_data_demux
// PURPOSE
//  Synthesisable, parametrised address demux for a core OBI-style data port. Routes each request to one of
//  NumTargets memory regions, an internal end-of-test mailbox, or an error responder. Returns responses to
//  the core strictly in order. Sits between redmule_complex core_data_req/rsp and the stack/TCDM/periph slaves.
// PARAMETERS
//  NumTargets     3             number of external target regions (1..8)
//  AddrWidth      32            address width
//  DataWidth      32            data width; BE width = DataWidth/8
//  MaxOutstanding 4             max accepted-but-unanswered requests (power of 2, >=1)
//  RegionBase     {..}          logic [NumTargets-1:0][AddrWidth-1:0] region base addresses
//  RegionSize     {..}          logic [NumTargets-1:0][AddrWidth-1:0] region sizes in bytes
//  MboxBase       32'h80000000  mailbox base; +0 = EOC/errors word, +4 = putchar
// PORTS
//  clk_i          in   1                   clock
//  rst_ni         in   1                   asynchronous reset, active low
//  core_req_i     in   1                   core request
//  core_gnt_o     out  1                   grant to core
//  core_addr_i    in   AddrWidth           byte address
//  core_we_i      in   1                   1 = write
//  core_be_i      in   DataWidth/8         byte enables
//  core_wdata_i   in   DataWidth           write data
//  core_rvalid_o  out  1                   response valid
//  core_rdata_o   out  DataWidth           read data
//  core_err_o     out  1                   response error (unmapped address), qualified by rvalid
//  tgt_req_o      out  NumTargets          per-target request
//  tgt_gnt_i      in   NumTargets          per-target grant
//  tgt_addr_o     out  AddrWidth           shared address to all targets
//  tgt_we_o       out  1                   shared write enable
//  tgt_be_o       out  DataWidth/8         shared byte enables
//  tgt_wdata_o    out  DataWidth           shared write data
//  tgt_rvalid_i   in   NumTargets          per-target response valid
//  tgt_rdata_i    in   NumTargets*DataWidth per-target read data, target i at [i*DataWidth +: DataWidth]
//  eoc_valid_o    out  1                   sticky: EOC word written since reset
//  eoc_code_o     out  32                  last value written to MboxBase+0
//  putc_valid_o   out  1                   1-cycle pulse on accepted write to MboxBase+4
//  putc_char_o    out  8                   wdata[7:0] of that write, held until next putc
//  rsp_unexp_o    out  1                   sticky: target rvalid while that target is not at FIFO head
// BEHAVIOUR
//  - Reset: all outputs 0; ID FIFO empty; internal response register clear.
//  - Decode (combinational): lowest-index region i with base<=addr<base+size wins. Otherwise addr[AW-1:3]
//    matches MboxBase -> MBOX. Otherwise ERR. Compute addr-base without overflow (AddrWidth+1 bits).
//  - Slot IDs: 0..NumTargets-1 external, NumTargets = MBOX, NumTargets+1 = ERR.
//  - ID FIFO: depth MaxOutstanding; push on core_req_i&core_gnt_o; pop on core_rvalid_o.
//    Simultaneous push+pop keeps count. Pointers wrap modulo depth.
//  - Stall rule: gnt=0 and no tgt_req_o asserted when (a) FIFO full and no pop this cycle, or (b) FIFO
//    non-empty and decoded slot != slot of last push. Rule (b) only pipelines to one slot at a time,
//    which guarantees in-order responses.
//  - External: tgt_req_o[i]=core_req_i when decoded to i and not stalled; core_gnt_o=tgt_gnt_i[i].
//  - MBOX/ERR: granted in the request cycle when not stalled. The response follows exactly 1 cycle later
//    through an internal register. MBOX read +0 -> eoc_code_o, +4 -> 0. ERR: rdata 0, err 1. Write to ERR
//    also responds with err 1.
//  - Response: core_rvalid_o = FIFO non-empty & head-slot valid (external: tgt_rvalid_i[head]; internal:
//    register). rdata muxed from head slot. Zero added latency for external targets.
//  - rvalid from target j != head (or FIFO empty) is dropped and sets rsp_unexp_o until reset.
//  - EOC write: eoc_code_o <= wdata[31:0] (BE ignored), eoc_valid_o <= 1. Each later write updates the code.
//  - Reset mid-operation clears FIFO and flags. Responses already in flight from targets after reset are
//    dropped and flagged per the rule above.
// TESTING
//  1 Read region0 base (target returns 32'hCAFE0001 after 2 cycles) -> tgt_req_o=3'b001, rvalid 2 cycles
//    after gnt, rdata CAFE0001, err 0.
//  2 Four back-to-back reads to region1, gnt always 1, responses delayed 3 cycles -> 4 accepts, 5th stalled
//    until first pop, data in order.
//  3 Read region0 then region2 immediately -> region2 request held (gnt 0, tgt_req_o[2]=0) until region0
//    responds; then issued.
//  4 Write 0x80000004 data 0x41 then 0x80000000 data 0 -> putc pulse with char 'A', eoc_valid_o=1, code 0;
//    each rvalid exactly 1 cycle after gnt.
//  5 Read 0x40000000 (unmapped) -> gnt same cycle, next cycle rvalid=1, err=1, rdata=0.
//  6 tgt_rvalid_i[1] with FIFO empty -> core_rvalid_o stays 0, rsp_unexp_o=1; assert rst_ni low -> all 0.

Source files
------------

// File: rtl/redmule_core_data_demux.sv
// Core data-port address demux: routes requests to NumTargets regions, an end-of-test mailbox
// or an error responder, and returns responses to the core strictly in request order.
module redmule_core_data_demux #(
    parameter int unsigned NumTargets     = 3,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [NumTargets-1:0][AddrWidth-1:0] RegionBase =
        {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NumTargets-1:0][AddrWidth-1:0] RegionSize =
        {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
    parameter logic [AddrWidth-1:0] MboxBase = 32'h8000_0000
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             core_req_i,
    output logic                             core_gnt_o,
    input  logic [AddrWidth-1:0]             core_addr_i,
    input  logic                             core_we_i,
    input  logic [DataWidth/8-1:0]           core_be_i,
    input  logic [DataWidth-1:0]             core_wdata_i,
    output logic                             core_rvalid_o,
    output logic [DataWidth-1:0]             core_rdata_o,
    output logic                             core_err_o,
    output logic [NumTargets-1:0]            tgt_req_o,
    input  logic [NumTargets-1:0]            tgt_gnt_i,
    output logic [AddrWidth-1:0]             tgt_addr_o,
    output logic                             tgt_we_o,
    output logic [DataWidth/8-1:0]           tgt_be_o,
    output logic [DataWidth-1:0]             tgt_wdata_o,
    input  logic [NumTargets-1:0]            tgt_rvalid_i,
    input  logic [NumTargets*DataWidth-1:0]  tgt_rdata_i,
    output logic                             eoc_valid_o,
    output logic [31:0]                      eoc_code_o,
    output logic                             putc_valid_o,
    output logic [7:0]                       putc_char_o,
    output logic                             rsp_unexp_o
);

    localparam int unsigned SlotW = $clog2(NumTargets + 2);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [SlotW-1:0] SlotMbox = SlotW'(NumTargets);
    localparam logic [SlotW-1:0] SlotErr  = SlotW'(NumTargets + 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [SlotW-1:0]     r_fifo [MaxOutstanding];
    logic [PtrW-1:0]      r_wptr, r_rptr;
    logic [CntW-1:0]      r_cnt;
    logic [SlotW-1:0]     r_last_slot;
    logic                 r_int_vld, r_int_err;
    logic [DataWidth-1:0] r_int_rdata;
    logic                 r_eoc_vld, r_putc_vld, r_unexp;
    logic [31:0]          r_eoc_code;
    logic [7:0]           r_putc_char;

    logic [SlotW-1:0]      w_slot, w_head;
    logic [AddrWidth:0]    w_off;
    logic                  w_empty, w_full, w_stall, w_push, w_pop, w_gnt, w_int_acc;
    logic                  w_rvalid, w_err;
    logic [DataWidth-1:0]  w_rdata;
    logic [NumTargets-1:0] w_tgt_req, w_exp_mask;

    // Walk regions from highest to lowest index so the lowest matching index wins.
    always_comb begin
        w_slot = SlotErr;
        w_off  = '0;
        if (core_addr_i[AddrWidth-1:3] == MboxBase[AddrWidth-1:3]) w_slot = SlotMbox;
        for (int i = NumTargets - 1; i >= 0; i--) begin
            w_off = {1'b0, core_addr_i} - {1'b0, RegionBase[i]};
            if (!w_off[AddrWidth] && (w_off[AddrWidth-1:0] < RegionSize[i])) w_slot = SlotW'(i);
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CntW'(MaxOutstanding));
    assign w_head  = r_fifo[r_rptr];

    always_comb begin
        w_rvalid   = 1'b0;
        w_rdata    = '0;
        w_err      = 1'b0;
        w_exp_mask = '0;
        if (!w_empty) begin
            if (w_head >= SlotMbox) begin
                w_rvalid = r_int_vld;
                w_rdata  = r_int_rdata;
                w_err    = r_int_err;
            end else begin
                for (int i = 0; i < NumTargets; i++) begin
                    if (w_head == SlotW'(i)) begin
                        w_exp_mask[i] = 1'b1;
                        w_rvalid      = tgt_rvalid_i[i];
                        w_rdata       = tgt_rdata_i[i*DataWidth +: DataWidth];
                    end
                end
            end
        end
        if (!w_rvalid) begin
            w_rdata = '0;
            w_err   = 1'b0;
        end
    end

    // Only one slot may be in flight at a time; that alone keeps responses in order.
    assign w_pop   = w_rvalid;
    assign w_stall = (w_full && !w_pop) || (!w_empty && (w_slot != r_last_slot));

    always_comb begin
        w_tgt_req = '0;
        w_gnt     = 1'b0;
        if (core_req_i && !w_stall) begin
            if (w_slot >= SlotMbox) begin
                w_gnt = 1'b1;
            end else begin
                for (int i = 0; i < NumTargets; i++) begin
                    if (w_slot == SlotW'(i)) begin
                        w_tgt_req[i] = 1'b1;
                        w_gnt        = tgt_gnt_i[i];
                    end
                end
            end
        end
    end

    assign w_push    = w_gnt;
    assign w_int_acc = w_push && (w_slot >= SlotMbox);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_last_slot <= '0;
            for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_slot;
                r_wptr         <= ptr_inc(r_wptr);
                r_last_slot    <= w_slot;
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
        end
    end

    // Mailbox and error responder answer through one register, exactly one cycle after grant.
    // The EOC word takes wdata[31:0] regardless of BE, so DataWidth must be at least 32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_int_vld   <= 1'b0;
            r_int_err   <= 1'b0;
            r_int_rdata <= '0;
            r_eoc_vld   <= 1'b0;
            r_eoc_code  <= '0;
            r_putc_vld  <= 1'b0;
            r_putc_char <= '0;
            r_unexp     <= 1'b0;
        end else begin
            r_int_vld   <= w_int_acc;
            r_int_err   <= w_int_acc && (w_slot == SlotErr);
            r_int_rdata <= '0;
            r_putc_vld  <= 1'b0;
            if (w_int_acc && (w_slot == SlotMbox)) begin
                if (core_we_i) begin
                    if (core_addr_i[2]) begin
                        r_putc_vld  <= 1'b1;
                        r_putc_char <= core_wdata_i[7:0];
                    end else begin
                        r_eoc_vld  <= 1'b1;
                        r_eoc_code <= core_wdata_i[31:0];
                    end
                end else if (!core_addr_i[2]) begin
                    r_int_rdata <= DataWidth'(r_eoc_code);
                end
            end
            if (|(tgt_rvalid_i & ~w_exp_mask)) r_unexp <= 1'b1;
        end
    end

    assign core_gnt_o    = w_gnt;
    assign core_rvalid_o = w_rvalid;
    assign core_rdata_o  = w_rdata;
    assign core_err_o    = w_err;
    assign tgt_req_o     = w_tgt_req;
    assign tgt_addr_o    = core_addr_i;
    assign tgt_we_o      = core_we_i;
    assign tgt_be_o      = core_be_i;
    assign tgt_wdata_o   = core_wdata_i;
    assign eoc_valid_o   = r_eoc_vld;
    assign eoc_code_o    = r_eoc_code;
    assign putc_valid_o  = r_putc_vld;
    assign putc_char_o   = r_putc_char;
    assign rsp_unexp_o   = r_unexp;

endmodule
